// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter.
//   OP_READ / OP_WRITE : encoding of mem_req_op
//   slot_state_e       : occupancy of the single output request slot
//   CNT_W              : width of the outstanding-request counters
//   GNT_RD / GNT_WR    : bit positions in the eligible / grant vectors
//   cnt_step()         : saturating-at-zero up/down counter step
package mem_arb_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int unsigned CNT_W = 4;

    localparam int unsigned GNT_RD = 0;
    localparam int unsigned GNT_WR = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // +1 on inc, -1 on dec, hold when both; never wraps below zero.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc,
                                                  input logic             dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            nxt = cnt - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker.
//   clk, rst_n : clock, asynchronous active-low reset
//   elig_i     : eligible vector, bit GNT_WR = write, bit GNT_RD = read
//   gnt_o      : one-hot (or zero) grant vector, same bit layout
// A single eligible requester is always granted; on a tie the requester
// not granted last wins. After reset "last" is read, so the first tie
// goes to write.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig_i,
    output logic [1:0] gnt_o
);

    logic last_wr_q;
    logic last_wr_d;

    always_comb begin
        gnt_o = '0;
        if (elig_i[GNT_WR] && elig_i[GNT_RD]) begin
            if (last_wr_q) begin
                gnt_o[GNT_RD] = 1'b1;
            end else begin
                gnt_o[GNT_WR] = 1'b1;
            end
        end else begin
            gnt_o = elig_i;
        end
    end

    always_comb begin
        last_wr_d = last_wr_q;
        if (gnt_o[GNT_WR]) begin
            last_wr_d = 1'b1;
        end else if (gnt_o[GNT_RD]) begin
            last_wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

endmodule

// File: rtl/mem_req_arb.sv
// Merges a write-request stream (MAC side) and a read-request stream (app
// side) into one memory request port through a single registered slot,
// tracks outstanding requests per type, and registers the write-done and
// read-response returns back to the requesters.
//   wr_req_*                   : write request in (val/rdy, addr, size, data)
//   rd_req_*                   : read request in (val/rdy, addr, size)
//   mem_req_*                  : merged request out (op 1=write, 0=read)
//   mem_wr_done_* / mem_rd_resp_* : completions from memory
//   write_complete_notif_*     : registered write completion
//   app_read_resp_*            : registered read response
//   err_o                      : sticky completion-underflow flag
`ifndef MSG_ADDR_WIDTH
`define MSG_ADDR_WIDTH 48
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module mem_req_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = `MSG_ADDR_WIDTH,
    parameter int unsigned SIZE_W  = `MSG_DATA_SIZE_WIDTH,
    parameter int unsigned DATA_W  = `NOC_DATA_WIDTH,
    parameter int unsigned MAX_OUT = 4
)(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              wr_req_val,
    output logic              wr_req_rdy,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [SIZE_W-1:0] wr_req_size,
    input  logic [DATA_W-1:0] wr_req_data,

    input  logic              rd_req_val,
    output logic              rd_req_rdy,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [SIZE_W-1:0] rd_req_size,

    output logic              mem_req_val,
    input  logic              mem_req_rdy,
    output logic              mem_req_op,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [SIZE_W-1:0] mem_req_size,
    output logic [DATA_W-1:0] mem_req_data,

    input  logic              mem_wr_done_val,
    input  logic [ADDR_W-1:0] mem_wr_done_addr,
    input  logic              mem_rd_resp_val,
    input  logic [DATA_W-1:0] mem_rd_resp_data,

    output logic              write_complete_notif_val,
    output logic [ADDR_W-1:0] write_complete_notif_addr,
    output logic              app_read_resp_val,
    output logic [DATA_W-1:0] app_read_resp_data,

    output logic              err_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    slot_state_e      state_q, state_d;
    logic             op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             err_q, err_d;
    logic             run_q;

    logic              wcn_val_q;
    logic [ADDR_W-1:0] wcn_addr_q;
    logic              rrsp_val_q;
    logic [DATA_W-1:0] rrsp_data_q;

    logic       slot_free;
    logic       grant;
    logic [1:0] elig;
    logic [1:0] gnt;

    // run_q is cleared asynchronously by reset and set on the first edge
    // after release; it keeps both readies low throughout reset without
    // feeding rst_n into the datapath.
    assign slot_free = run_q & ((state_q == EMPTY) | mem_req_rdy);

    // A read is held off while any write is still outstanding.
    assign elig[GNT_WR] = wr_req_val & slot_free & (wr_cnt_q < MAX_CNT);
    assign elig[GNT_RD] = rd_req_val & slot_free & (rd_cnt_q < MAX_CNT) &
                          (wr_cnt_q == '0);

    mem_arb_rr u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .elig_i (elig),
        .gnt_o  (gnt)
    );

    assign grant      = gnt[GNT_WR] | gnt[GNT_RD];
    assign wr_req_rdy = gnt[GNT_WR];
    assign rd_req_rdy = gnt[GNT_RD];

    // Slot FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (grant) state_d = FULL;
                   else if (mem_req_rdy) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Slot FSM: outputs
    always_comb begin
        mem_req_val  = (state_q == FULL);
        mem_req_op   = op_q;
        mem_req_addr = addr_q;
        mem_req_size = size_q;
        mem_req_data = data_q;
    end

    // Slot payload capture on grant; held otherwise.
    always_comb begin
        op_d   = op_q;
        addr_d = addr_q;
        size_d = size_q;
        data_d = data_q;
        if (gnt[GNT_WR]) begin
            op_d   = OP_WRITE;
            addr_d = wr_req_addr;
            size_d = wr_req_size;
            data_d = wr_req_data;
        end else if (gnt[GNT_RD]) begin
            op_d   = OP_READ;
            addr_d = rd_req_addr;
            size_d = rd_req_size;
            data_d = '0;
        end
    end

    always_comb begin
        wr_cnt_d = cnt_step(wr_cnt_q, gnt[GNT_WR], mem_wr_done_val);
        rd_cnt_d = cnt_step(rd_cnt_q, gnt[GNT_RD], mem_rd_resp_val);
        err_d    = err_q |
                   (mem_wr_done_val & (wr_cnt_q == '0)) |
                   (mem_rd_resp_val & (rd_cnt_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_READ;
            addr_q      <= '0;
            size_q      <= '0;
            data_q      <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_q       <= 1'b0;
            run_q       <= 1'b0;
            wcn_val_q   <= 1'b0;
            wcn_addr_q  <= '0;
            rrsp_val_q  <= 1'b0;
            rrsp_data_q <= '0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            data_q      <= data_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_q       <= err_d;
            run_q       <= 1'b1;
            wcn_val_q   <= mem_wr_done_val;
            rrsp_val_q  <= mem_rd_resp_val;
            if (mem_wr_done_val) wcn_addr_q  <= mem_wr_done_addr;
            if (mem_rd_resp_val) rrsp_data_q <= mem_rd_resp_data;
        end
    end

    assign write_complete_notif_val  = wcn_val_q;
    assign write_complete_notif_addr = wcn_addr_q;
    assign app_read_resp_val         = rrsp_val_q;
    assign app_read_resp_data        = rrsp_data_q;
    assign err_o                     = err_q;

endmodule
